// File: rtl/uart_tx_scheduler_if.sv
// Requester-side byte handshake plus the Wishbone write port toward the UART.
// The master modport is the scheduler's view; slave is the environment's.
interface uart_tx_scheduler_if #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DAT_WIDTH = 64,
    parameter int unsigned ADR_WIDTH = 32
);
    logic [NREQ-1:0]      req_valid_i;
    logic [8*NREQ-1:0]    req_data_i;
    logic [NREQ-1:0]      req_ready_o;

    logic                 uart_cyc_o;
    logic                 uart_stb_o;
    logic                 uart_we_o;
    logic [ADR_WIDTH-1:0] uart_adr_o;
    logic [DAT_WIDTH-1:0] uart_dat_o;
    logic                 uart_ack_i;
    logic                 uart_err_i;

    modport master (
        input  req_valid_i, req_data_i, uart_ack_i, uart_err_i,
        output req_ready_o, uart_cyc_o, uart_stb_o, uart_we_o, uart_adr_o, uart_dat_o
    );

    modport slave (
        output req_valid_i, req_data_i, uart_ack_i, uart_err_i,
        input  req_ready_o, uart_cyc_o, uart_stb_o, uart_we_o, uart_adr_o, uart_dat_o
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte sources:
// one Wishbone write per byte, then a fixed hold-off while the frame drains.
module uart_tx_scheduler #(
    parameter int unsigned          NREQ        = 4,
    parameter int unsigned          DAT_WIDTH   = 64,
    parameter int unsigned          ADR_WIDTH   = 32,
    parameter logic [ADR_WIDTH-1:0] UART_ADDR   = ADR_WIDTH'(0),
    parameter int unsigned          GAP_CYCLES  = 21840,
    parameter int unsigned          ACK_TIMEOUT = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    uart_tx_scheduler_if.master    bus,
    output logic [NREQ-1:0]        grant_o,
    output logic                   busy_o,
    output logic                   err_o
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned TMO_W = $clog2(ACK_TIMEOUT + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_GAP   = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       last_q, last_d;
    logic [NREQ-1:0]        grant_q, grant_d;
    logic                   wr_q, wr_d;
    logic [ADR_WIDTH-1:0]   adr_q, adr_d;
    logic [DAT_WIDTH-1:0]   dat_q, dat_d;
    logic                   err_q, err_d;
    logic [TMO_W-1:0]       tmo_q, tmo_d;
    logic [GAP_W-1:0]       gap_q, gap_d;

    logic                   win_vld_c;
    logic [IDX_W-1:0]       win_idx_c;
    logic [NREQ-1:0]        win_oh_c;
    logic [7:0]             win_byte_c;
    logic                   abort_c;

    // Rotating priority search starting just after the last owner.
    always_comb begin
        int unsigned k;
        k         = 0;
        win_vld_c = 1'b0;
        win_idx_c = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            k = (32'(last_q) + i) % NREQ;
            if (!win_vld_c && bus.req_valid_i[IDX_W'(k)]) begin
                win_vld_c = 1'b1;
                win_idx_c = IDX_W'(k);
            end
        end
    end

    assign win_oh_c        = NREQ'(1) << win_idx_c;
    assign win_byte_c      = bus.req_data_i[{win_idx_c, 3'b000} +: 8];
    assign bus.req_ready_o = (state_q == S_IDLE && win_vld_c) ? win_oh_c : '0;

    // An error response wins over a simultaneous ack; silence is an error too.
    assign abort_c = bus.uart_err_i ||
                     (!bus.uart_ack_i && tmo_q == TMO_W'(ACK_TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        wr_d    = wr_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        err_d   = 1'b0;
        tmo_d   = tmo_q;
        gap_d   = gap_q;

        case (state_q)
            S_IDLE: begin
                if (win_vld_c) begin
                    state_d = S_WRITE;
                    last_d  = win_idx_c;
                    grant_d = win_oh_c;
                    wr_d    = 1'b1;
                    adr_d   = UART_ADDR;
                    dat_d   = DAT_WIDTH'(win_byte_c);
                    tmo_d   = '0;
                end
            end
            S_WRITE: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (abort_c || bus.uart_ack_i) begin
                    state_d = S_GAP;
                    wr_d    = 1'b0;
                    adr_d   = '0;
                    err_d   = abort_c;
                    gap_d   = GAP_W'(GAP_CYCLES - 1);
                end
            end
            S_GAP: begin
                if (gap_q == '0) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
                wr_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            last_q  <= IDX_W'(NREQ - 1);
            grant_q <= '0;
            wr_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            err_q   <= 1'b0;
            tmo_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            wr_q    <= wr_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            err_q   <= err_d;
            tmo_q   <= tmo_d;
            gap_q   <= gap_d;
        end
    end

    assign bus.uart_cyc_o = wr_q;
    assign bus.uart_stb_o = wr_q;
    assign bus.uart_we_o  = wr_q;
    assign bus.uart_adr_o = adr_q;
    assign bus.uart_dat_o = dat_q;
    assign grant_o        = grant_q;
    assign busy_o         = (state_q != S_IDLE);
    assign err_o          = err_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed plus random bench for uart_tx_scheduler, checked every cycle against
// a timeline model: accept, WRITE for the slave's latency, GAP, then IDLE.
module tb_uart_tx_scheduler;

    localparam int NREQ = 4;
    localparam int IW   = 2;
    localparam int DW   = 64;
    localparam int AW   = 32;
    localparam logic [AW-1:0] ADDR = 32'hA000_0010;
    localparam int GAP  = 8;
    localparam int TMO  = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_tx_scheduler_if #(.NREQ(NREQ), .DAT_WIDTH(DW), .ADR_WIDTH(AW)) bus ();

    logic [NREQ-1:0] grant;
    logic            busy;
    logic            err;

    uart_tx_scheduler #(
        .NREQ(NREQ), .DAT_WIDTH(DW), .ADR_WIDTH(AW), .UART_ADDR(ADDR),
        .GAP_CYCLES(GAP), .ACK_TIMEOUT(TMO)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_n),
        .bus     (bus),
        .grant_o (grant),
        .busy_o  (busy),
        .err_o   (err)
    );

    // requesters
    logic [NREQ-1:0] vld;
    logic [7:0]      rbyte [NREQ];
    assign bus.req_valid_i = vld;
    assign bus.req_data_i  = {rbyte[3], rbyte[2], rbyte[1], rbyte[0]};

    // slave: mode 0 acks, 1 stays silent, 2 answers ack+err; one cycle after stb
    int   mode;
    logic stray;
    logic ack_r, err_r;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            ack_r <= (mode != 1) && bus.uart_stb_o && !ack_r && !err_r;
            err_r <= (mode == 2) && bus.uart_stb_o && !ack_r && !err_r;
        end
    end
    assign bus.uart_ack_i = ack_r | stray;
    assign bus.uart_err_i = err_r;

    int errors = 0;
    int checks = 0;

    // reference model state
    int         cyc_n = 0;
    int         a_cyc, e_cyc, wk, last_ref;
    bit         e_err;
    bit         rand_mode;
    logic [7:0] wbyte;
    int         stb_cnt, err_cnt;
    logic [7:0] obs_byte_q [$];
    logic [3:0] obs_grant_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_winner(input logic [NREQ-1:0] v, input int last);
        for (int i = 1; i <= NREQ; i++)
            if (v[IW'((last + i) % NREQ)]) return (last + i) % NREQ;
        return -1;
    endfunction

    task automatic req(input int k, input logic [7:0] b);
        vld[IW'(k)]   = 1'b1;
        rbyte[IW'(k)] = b;
    endtask

    // One clock: sample at negedge against the model, advance, drop accepted valids.
    task automatic tick();
        logic [NREQ-1:0] exp_rdy, dut_acc;
        int  w;
        bit  eb, es;
        @(negedge clk);
        cyc_n++;
        eb = (cyc_n > a_cyc) && (cyc_n <= e_cyc + GAP);
        es = (cyc_n > a_cyc) && (cyc_n <= e_cyc);
        exp_rdy = '0;
        w = -1;
        if (!eb && vld != '0) begin
            w = ref_winner(vld, last_ref);
            exp_rdy = 4'(1) << w;
        end
        chk("req_ready", 64'(bus.req_ready_o), 64'(exp_rdy));
        chk("busy", 64'(busy), 64'(eb));
        chk("grant", 64'(grant), eb ? 64'(4'(1) << wk) : 64'(0));
        chk("stb", 64'(bus.uart_stb_o), 64'(es));
        chk("cyc", 64'(bus.uart_cyc_o), 64'(es));
        chk("we", 64'(bus.uart_we_o), 64'(es));
        chk("err_o", 64'(err), 64'((cyc_n == e_cyc + 1) && e_err));
        if (es) begin
            chk("adr", 64'(bus.uart_adr_o), 64'(ADDR));
            chk("dat", bus.uart_dat_o, {56'b0, wbyte});
        end
        if (cyc_n == a_cyc + 1) begin
            obs_byte_q.push_back(bus.uart_dat_o[7:0]);
            obs_grant_q.push_back(grant);
        end
        if (bus.uart_stb_o) stb_cnt++;
        if (err) err_cnt++;
        dut_acc = bus.req_ready_o & vld;
        if (w >= 0) begin
            if (rand_mode) mode = int'($urandom_range(0, 2));
            a_cyc    = cyc_n;
            e_cyc    = cyc_n + ((mode == 1) ? TMO : 2);
            e_err    = (mode != 0);
            wk       = w;
            wbyte    = rbyte[IW'(w)];
            last_ref = w;
        end
        @(posedge clk);
        #1;
        vld = vld & ~dut_acc;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while ((vld != '0 || cyc_n <= e_cyc + GAP) && n < maxc) begin
            tick();
            n++;
        end
        chk("drain_bound", 64'(n < maxc), 64'(1));
    endtask

    task automatic expect_write(input string tag, input logic [7:0] b, input logic [3:0] g);
        chk({tag, "_present"}, 64'(obs_byte_q.size() > 0), 64'(1));
        if (obs_byte_q.size() > 0) begin
            chk({tag, "_byte"}, 64'(obs_byte_q.pop_front()), 64'(b));
            chk({tag, "_grant"}, 64'(obs_grant_q.pop_front()), 64'(g));
        end
    endtask

    task automatic model_reset();
        vld      = '0;
        mode     = 0;
        last_ref = NREQ - 1;
        a_cyc    = -100;
        e_cyc    = -100;
        e_err    = 1'b0;
        wk       = 0;
        wbyte    = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_stb"}, 64'(bus.uart_stb_o), 64'(0));
        chk({tag, "_cyc"}, 64'(bus.uart_cyc_o), 64'(0));
        chk({tag, "_we"}, 64'(bus.uart_we_o), 64'(0));
        chk({tag, "_adr"}, 64'(bus.uart_adr_o), 64'(0));
        chk({tag, "_dat"}, bus.uart_dat_o, 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        chk({tag, "_grant"}, 64'(grant), 64'(0));
        chk({tag, "_err"}, 64'(err), 64'(0));
    endtask

    initial begin
        rst_n     = 1'b0;
        stray     = 1'b0;
        rand_mode = 1'b0;
        stb_cnt   = 0;
        err_cnt   = 0;
        for (int k = 0; k < NREQ; k++) rbyte[k] = 8'h00;
        model_reset();
        #1;
        check_reset_outputs("por");
        chk("por_ready", 64'(bus.req_ready_o), 64'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // single byte from requester 0, then a stray ack while idle
        req(0, 8'h41);
        drain(40);
        expect_write("single", 8'h41, 4'b0001);
        stray = 1'b1;
        tick();
        stray = 1'b0;
        tick();

        // reset asserted mid-WRITE drops the bus without a clock edge
        req(1, 8'h52);
        tick();
        chk("rst_mid_stb_before", 64'(bus.uart_stb_o), 64'(1));
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_mid");
        model_reset();
        obs_byte_q.delete();
        obs_grant_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // all four valid: strict rotation from requester 0
        req(0, "A"); req(1, "B"); req(2, "C"); req(3, "D");
        drain(100);
        expect_write("rr0", "A", 4'b0001);
        expect_write("rr1", "B", 4'b0010);
        expect_write("rr2", "C", 4'b0100);
        expect_write("rr3", "D", 4'b1000);

        // after req2 owns the bus, req3 outranks req1
        req(2, 8'h33);
        drain(40);
        expect_write("rot_a", 8'h33, 4'b0100);
        req(1, 8'h11); req(3, 8'h44);
        drain(60);
        expect_write("rot_b", 8'h44, 4'b1000);
        expect_write("rot_c", 8'h11, 4'b0010);

        // silent slave: timeout abort, then a normal byte
        mode = 1; stb_cnt = 0; err_cnt = 0;
        req(0, 8'h5A);
        drain(40);
        chk("tmo_stb_cycles", 64'(stb_cnt), 64'(TMO));
        chk("tmo_err_pulses", 64'(err_cnt), 64'(1));
        expect_write("tmo", 8'h5A, 4'b0001);
        mode = 0; stb_cnt = 0; err_cnt = 0;
        req(1, 8'h6B);
        drain(40);
        chk("post_tmo_stb_cycles", 64'(stb_cnt), 64'(2));
        chk("post_tmo_err_pulses", 64'(err_cnt), 64'(0));
        expect_write("post_tmo", 8'h6B, 4'b0010);

        // ack+err together is an error; the byte is not resent and priority moves on
        mode = 2; err_cnt = 0;
        req(2, 8'h7C);
        drain(40);
        chk("errack_err_pulses", 64'(err_cnt), 64'(1));
        expect_write("errack", 8'h7C, 4'b0100);
        mode = 0;
        req(2, 8'h7D); req(3, 8'h7E);
        drain(60);
        expect_write("post_err_a", 8'h7E, 4'b1000);
        expect_write("post_err_b", 8'h7D, 4'b0100);
        chk("no_resend", 64'(obs_byte_q.size()), 64'(0));

        // random traffic with random slave behaviour per byte
        rand_mode = 1'b1;
        repeat (200) begin
            for (int k = 0; k < NREQ; k++)
                if (!vld[IW'(k)] && $urandom_range(0, 3) == 0) req(k, 8'($urandom));
            tick();
        end
        rand_mode = 1'b0;
        drain(100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Round-robin scheduler that shares the single UART transmitter among NREQ byte requesters (CPU console, debug monitor, boot loader, ...).
- Sits between the requesters and the UART Wishbone slave port, acting as Wishbone master.
- Issues one single-beat write per byte, then holds off the next write long enough for the frame to leave the wire, because the transmitter silently drops writes while busy.

Parameters:
NREQ, 4, number of requesters (2..8)
DAT_WIDTH, 64, Wishbone data width
ADR_WIDTH, 32, Wishbone address width
UART_ADDR, 32'h0, address driven on every write
GAP_CYCLES, 21840, clk_i cycles between ack and next write (12 bit periods at 1820 clk/bit: 10-bit frame plus baud-clock phase slack)
ACK_TIMEOUT, 16, clk_i cycles in WRITE without ack/err before abort

Ports:
clk_i  in  1  system clock
rst_i  in  1  reset, asynchronous, active-low
req_valid_i  in  NREQ  per-requester byte valid
req_data_i  in  8*NREQ  byte k on [8k+7:8k]
req_ready_o  out  NREQ  accept strobe, one-hot or zero
uart_cyc_o  out  1  Wishbone cycle
uart_stb_o  out  1  Wishbone strobe
uart_we_o  out  1  Wishbone write enable
uart_adr_o  out  ADR_WIDTH  Wishbone address
uart_dat_o  out  DAT_WIDTH  Wishbone write data
uart_ack_i  in  1  Wishbone ack
uart_err_i  in  1  Wishbone error
grant_o  out  NREQ  one-hot owner of the byte in flight/gap, 0 in IDLE
busy_o  out  1  high when state != IDLE
err_o  out  1  one-cycle pulse on err_i or timeout

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is asynchronous and active-low.
- Reset (asynchronous, immediate, also mid-transfer):
  - state = IDLE; cyc/stb/we = 0; adr = 0; dat = 0.
  - grant_o = 0, busy_o = 0, err_o = 0.
  - Round-robin pointer last = NREQ-1, so requester 0 has first priority.
  - Gap and timeout counters = 0.
- Handshake: a byte transfers on a clk_i edge where req_valid_i[k] & req_ready_o[k]. Requesters hold valid and data stable until accepted; valid must not drop before ready.
- req_ready_o is combinational. Only in IDLE is it nonzero: one-hot at the winner, 0 in every other state.
- Winner: first k with valid set, searching last+1, last+2, ... modulo NREQ.
- IDLE:
  - No valid: stay.
  - On accept:
    - latch byte k into dat[7:0], upper bits 0;
    - last <= k; grant_o <= one-hot k;
    - timeout counter <= 0; go WRITE.
- WRITE:
  - cyc = stb = we = 1, adr = UART_ADDR. Asserted the cycle after accept (latency 1 from accept edge).
  - Counter increments each cycle.
  - ack_i: drop cyc/stb/we next edge; gap counter <= GAP_CYCLES-1; go GAP.
  - err_i, or counter == ACK_TIMEOUT-1 with no ack: drop cyc/stb/we; pulse err_o; load gap; go GAP. The byte is dropped, never retried.
  - ack_i and err_i in the same cycle: treat as err.
- GAP:
  - Bus idle; decrement counter; at 0 go IDLE and clear grant_o.
  - GAP lasts exactly GAP_CYCLES cycles. Next accept is possible on the following edge.
- ack_i/err_i outside WRITE: ignored.
- Fairness: with all requesters valid, grants rotate 0,1,2,3,0,... No requester waits more than NREQ-1 foreign bytes.
- Only one byte is outstanding at a time. No buffering beyond the latched byte.

Test Plan (override GAP_CYCLES=8, ACK_TIMEOUT=4, slave acks 1 cycle after stb):
1. Reset mid-WRITE: deassert rst_i while stb=1 -> cyc/stb drop in same cycle without clock; after release req0 granted first.
2. Single byte: req_valid_i=4'b0001, data 8'h41 -> ready[0] pulses 1 cycle; next cycle stb=1, dat_o=64'h41, adr=UART_ADDR; ack -> GAP of 8 cycles, busy_o low after.
3. Round-robin: all 4 valid with bytes 'A','B','C','D' held, each dropping after accept -> writes in order A,B,C,D; grant_o 0001,0010,0100,1000; no write within 8 cycles of the previous ack.
4. Pointer rotation: after granting req2, set req1 and req3 valid -> req3 granted before req1.
5. Timeout: slave never acks -> stb high exactly 4 cycles, err_o pulses once, then GAP; next byte proceeds normally.
6. Error: slave returns err_i and ack_i together -> treated as error, err_o pulse, byte not resent, grant advances to next requester.
